iir_output_stage: RTL

IIR_OUTPUT_STAGE -- requirements
Module: iir_output_stage

---
 rtl/iir_output_stage_if.sv | 22 ++
 rtl/iir_output_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/iir_output_stage_if.sv
// Sample stream into the IIR output stage and FWFT stream out of its FIFO.
interface iir_output_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] y_in;
    logic                  y_valid;
    logic [GAIN_WIDTH-1:0] gain;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output y_in, y_valid, gain, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  y_in, y_valid, gain, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/iir_output_stage.sv
// IIR output stage: decimation, Q2 gain with round/saturate, and an output FIFO
// with sticky saturation and overflow flags.
module iir_output_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    iir_output_stage_if.slave             bus,
    input  logic [3:0]                    dec_factor,
    input  logic                          clr_flags,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          sat_flag,
    output logic                          ovf_flag
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic signed [PW:0] RND  = {{(PW-GAIN_WIDTH+3){1'b0}}, 1'b1, {(GAIN_WIDTH-3){1'b0}}};
    localparam logic signed [PW:0] MAXV = {{(GAIN_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] MINV = {{(GAIN_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Decimator: the ratio is latched whenever the counter sits at 0, so a new
    // dec_factor only takes effect at a wrap.
    logic [3:0] dec_cnt, dec_q, dec_eff;
    logic       keep;

    always_comb begin
        dec_eff = (dec_factor == 4'd0) ? 4'd1 : dec_factor;
        keep    = bus.y_valid && (dec_cnt == 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt <= '0;
            dec_q   <= 4'd1;
        end else if (bus.y_valid) begin
            if (dec_cnt == 4'd0) begin
                dec_q   <= dec_eff;
                dec_cnt <= (dec_eff == 4'd1) ? 4'd0 : 4'd1;
            end else if (dec_cnt == dec_q - 4'd1) begin
                dec_cnt <= '0;
            end else begin
                dec_cnt <= dec_cnt + 4'd1;
            end
        end
    end

    logic                   s1_valid;
    logic signed [PW-1:0]   s1_prod;
    logic signed [PW:0]     rnd_sum, shifted;
    logic                   sat_hi, sat_lo;
    logic [DATA_WIDTH-1:0]  s2_res;
    logic                   s2_valid, s2_sat;
    logic [DATA_WIDTH-1:0]  s2_data;
    logic                   wr_valid;
    logic [DATA_WIDTH-1:0]  wr_data;

    always_comb begin
        rnd_sum = {s1_prod[PW-1], s1_prod} + RND;
        shifted = rnd_sum >>> (GAIN_WIDTH - 2);
        sat_hi  = shifted > MAXV;
        sat_lo  = shifted < MINV;
        s2_res  = shifted[DATA_WIDTH-1:0];
        if (sat_hi) s2_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        if (sat_lo) s2_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s2_valid <= 1'b0;
            s2_sat   <= 1'b0;
            s2_data  <= '0;
            wr_valid <= 1'b0;
            wr_data  <= '0;
        end else begin
            s1_valid <= keep;
            s1_prod  <= PW'($signed(bus.y_in)) * PW'($signed(bus.gain));
            s2_valid <= s1_valid;
            s2_sat   <= s1_valid && (sat_hi || sat_lo);
            s2_data  <= s2_res;
            wr_valid <= s2_valid;
            wr_data  <= s2_data;
        end
    end

    // FIFO: a write into a full FIFO is still accepted when a pop frees a slot
    // on the same edge.
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  full, pop, accept, drop;

    always_comb begin
        full          = fifo_count == CW'(FIFO_DEPTH);
        bus.out_valid = fifo_count != '0;
        bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
        pop           = bus.out_valid && bus.out_ready;
        accept        = wr_valid && (!full || pop);
        drop          = wr_valid && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            sat_flag   <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !accept) fifo_count <= fifo_count - 1'b1;
            sat_flag <= (sat_flag && !clr_flags) || (s2_valid && s2_sat);
            ovf_flag <= (ovf_flag && !clr_flags) || drop;
        end
    end
endmodule
